divider24x8: RTL and testbench

DIVIDER24X8 -- requirements
Module: divider24x8

---
 rtl/divider_pkg.sv | 26 ++
 rtl/divider24x8_div_step.sv | 31 +++
 rtl/divider24x8.sv | 126 ++++++++++++
 tb/tb_divider24x8.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared widths, FSM encoding and counter sizing for divider24x8
//
// Contents:
//   DEF_DW_DIVIDEND / DEF_DW_DIVISOR : default operand widths
//   state_t                          : FSM encoding (IDLE=0, CALC=1, DONE=2)
//   cnt_width()                      : bit-counter width for a given dividend width
//   CNT_W                            : bit-counter width for the default dividend width
package divider_pkg;

    localparam int DEF_DW_DIVIDEND = 24;
    localparam int DEF_DW_DIVISOR  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter only has to reach dw-1; keep at least one bit for dw == 1.
    function automatic int cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_DW_DIVIDEND);

endpackage

// File: rtl/divider24x8_div_step.sv
// rtl/divider24x8_div_step.sv - one restoring shift-subtract step (combinational)
//
// Ports:
//   rem_in  [DW_DIVISOR:0]   : working remainder before this step
//   bit_in                   : next dividend bit (MSB first)
//   divisor [DW_DIVISOR-1:0] : latched divisor
//   q_bit                    : quotient bit produced by this step
//   rem_out [DW_DIVISOR:0]   : working remainder after this step
module div_step #(
    parameter int DW_DIVISOR = 8
) (
    input  logic [DW_DIVISOR:0]   rem_in,
    input  logic                  bit_in,
    input  logic [DW_DIVISOR-1:0] divisor,
    output logic                  q_bit,
    output logic [DW_DIVISOR:0]   rem_out
);

    logic [DW_DIVISOR+1:0] shifted;
    logic [DW_DIVISOR:0]   diff;

    assign shifted = {rem_in, bit_in};

    // For a non-zero divisor the shifted value is below 2*divisor, so its top
    // bit is clear and the narrower subtraction is exact. With a zero divisor
    // the remainder degenerates into a plain shift register of dividend bits.
    assign diff    = shifted[DW_DIVISOR:0] - {1'b0, divisor};
    assign q_bit   = (shifted >= {2'b00, divisor});
    assign rem_out = q_bit ? diff : shifted[DW_DIVISOR:0];

endmodule

// File: rtl/divider24x8.sv
// rtl/divider24x8.sv - sequential unsigned divider, one quotient bit per cycle
//
// Optional feature macro: DIVIDER24X8_DBZ_ERR_EN (adds dbz_err and a fast
// divide-by-zero path straight to DONE).
//
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   start                     : division request, honoured only in IDLE
//   dividend [DW_DIVIDEND-1:0]: numerator, captured with start
//   divisor  [DW_DIVISOR-1:0] : denominator, captured with start
//   busy                      : high in CALC and DONE
//   done                      : one-cycle pulse with fresh results
//   quotient [DW_DIVIDEND-1:0]: result, held until the next DONE
//   remainder[DW_DIVISOR-1:0] : result, held until the next DONE
//   dbz_err                   : (macro only) last division had a zero divisor
module divider24x8
    import divider_pkg::*;
#(
    parameter int DW_DIVIDEND = DEF_DW_DIVIDEND,
    parameter int DW_DIVISOR  = DEF_DW_DIVISOR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DW_DIVIDEND-1:0] dividend,
    input  logic [DW_DIVISOR-1:0]  divisor,
    output logic                   busy,
    output logic                   done,
    output logic [DW_DIVIDEND-1:0] quotient,
    output logic [DW_DIVISOR-1:0]  remainder
`ifdef DIVIDER24X8_DBZ_ERR_EN
    ,
    output logic                   dbz_err
`endif
);

    localparam int             CW   = cnt_width(DW_DIVIDEND);
    localparam logic [CW-1:0]  LAST = CW'(DW_DIVIDEND - 1);

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [DW_DIVIDEND-1:0] dvd;   // dividend bits shift out, quotient bits shift in
    logic [DW_DIVISOR-1:0]  dvs;
    logic [DW_DIVISOR:0]    rem;
    logic                   q_bit;
    logic [DW_DIVISOR:0]    rem_nxt;
    logic [DW_DIVIDEND-1:0] quo_nxt;

    div_step #(
        .DW_DIVISOR (DW_DIVISOR)
    ) u_step (
        .rem_in  (rem),
        .bit_in  (dvd[DW_DIVIDEND-1]),
        .divisor (dvs),
        .q_bit   (q_bit),
        .rem_out (rem_nxt)
    );

    assign quo_nxt = {dvd[DW_DIVIDEND-2:0], q_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIVIDER24X8_DBZ_ERR_EN
            dbz_err   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd  <= dividend;
                        dvs  <= divisor;
                        rem  <= '0;
                        cnt  <= '0;
                        busy <= 1'b1;
`ifdef DIVIDER24X8_DBZ_ERR_EN
                        if (divisor == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= '0;
                            remainder <= '0;
                            dbz_err   <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    dvd <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        quotient  <= quo_nxt;
                        remainder <= rem_nxt[DW_DIVISOR-1:0];
`ifdef DIVIDER24X8_DBZ_ERR_EN
                        dbz_err   <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider24x8.sv
// tb/tb_divider24x8.sv - scoreboard-driven directed bench for divider24x8
module tb_divider24x8;

`ifdef DIVIDER24X8_DBZ_ERR_EN
    localparam bit DBZ_ON = 1'b1;
`else
    localparam bit DBZ_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [23:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [23:0] quotient;
    logic [7:0]  remainder;
    logic        dbz_obs;

    divider24x8 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIVIDER24X8_DBZ_ERR_EN
        ,
        .dbz_err   (dbz_obs)
`endif
    );

`ifndef DIVIDER24X8_DBZ_ERR_EN
    assign dbz_obs = 1'b0;
`endif

    typedef struct {
        logic [23:0] q;
        logic [7:0]  r;
        int          lat;
        logic        dbz;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [23:0] last_q = 24'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [23:0] a, input logic [7:0] b, input int start_cyc);
        exp_t e;
        if (b == 8'd0) begin
            e.q   = DBZ_ON ? 24'd0 : 24'hFFFFFF;
            e.r   = DBZ_ON ? 8'd0 : a[7:0];
            e.lat = start_cyc + (DBZ_ON ? 0 : 24);
            e.dbz = DBZ_ON;
        end else begin
            e.q   = a / {16'd0, b};
            e.r   = 8'(a % {16'd0, b});
            e.lat = start_cyc + 24;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic check_done(input string tag, input int cyc);
        exp_t e;
        e = sb.pop_front();
        check({tag, "_latency"}, cyc, e.lat);
        check({tag, "_quotient"}, {8'd0, quotient}, {8'd0, e.q});
        check({tag, "_remainder"}, {24'd0, remainder}, {24'd0, e.r});
        check({tag, "_dbz_err"}, {31'd0, dbz_obs}, {31'd0, e.dbz});
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
        last_q = e.q;
    endtask

    // Cycle 1 is the cycle right after the start edge. inj > 0 pulses a
    // second start with different operands in that cycle, which must be ignored.
    task automatic run_div(input string tag, input logic [23:0] a, input logic [7:0] b, input int inj);
        int cyc;
        sb.push_back(model(a, b, 1));
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 60) begin
            check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
            if (inj != 0 && cyc == inj) begin
                check({tag, "_result_held"}, {8'd0, quotient}, {8'd0, last_q});
                dividend = 24'd50;
                divisor  = 8'd5;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        check_done(tag, cyc);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse_end"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int  cyc;
        int  ndone;
        logic seen;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = 24'd0;
        divisor  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_quotient", {8'd0, quotient}, 32'd0);
        check("reset_remainder", {24'd0, remainder}, 32'd0);
        check("reset_dbz_err", {31'd0, dbz_obs}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_div("d1000000_7", 24'd1000000, 8'd7, 0);
        run_div("dffffff_ff", 24'hFFFFFF, 8'hFF, 0);
        run_div("d100_200", 24'd100, 8'd200, 5);

        // Abort 1000/3 at cycle 10 with an asynchronous reset.
        @(negedge clk);
        dividend = 24'd1000;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 1;
        while (cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_quotient", {8'd0, quotient}, 32'd0);
        check("abort_remainder", {24'd0, remainder}, 32'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("abort_no_done", {31'd0, seen}, 32'd0);
        last_q = 24'd0;
        run_div("d1000_3", 24'd1000, 8'd3, 0);

        run_div("d1234_0", 24'h001234, 8'd0, 0);
        run_div("d9_3", 24'd9, 8'd3, 0);

        // Start held high: second division begins on return to IDLE.
        sb.push_back(model(24'd5, 8'd2, 1));
        sb.push_back(model(24'd5, 8'd2, 27));
        @(negedge clk);
        dividend = 24'd5;
        divisor  = 8'd2;
        start    = 1'b1;
        @(posedge clk);
        #1;
        cyc   = 1;
        ndone = 0;
        while (ndone < 2 && cyc < 80) begin
            if (done === 1'b1) begin
                check_done("b2b", cyc);
                ndone++;
                if (ndone == 2) start = 1'b0;
            end
            if (ndone < 2) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start = 1'b0;
        check("b2b_done_count", ndone, 32'd2);
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
